// File: rtl/sha3_scan_dispatcher.sv
// Dispatches a header job to a SHA3 nonce scanner in fixed-size chunks and
// reports the first find, completion of all chunks, or an abort.
module sha3_scan_dispatcher #(
  parameter int PROPER     = 1,
  parameter int NONCE_WORD = 19,
  localparam int INPUT_ELEMENTS = (PROPER != 0) ? 20 : 24
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           job_valid,
  output logic                           job_ready,
  input  logic [INPUT_ELEMENTS-1:0][31:0] job_blobby,
  input  logic [31:0]                    job_first_nonce,
  input  logic [15:0]                    job_chunks,
  input  logic                           abort,
  output logic                           scan_start,
  output logic [INPUT_ELEMENTS-1:0][31:0] scan_blobby,
  input  logic                           scan_idle,
  input  logic                           scan_found,
  input  logic [31:0]                    scan_nonce,
  input  logic [31:0]                    scan_count,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           res_found,
  output logic                           res_aborted,
  output logic [31:0]                    res_nonce,
  output logic [15:0]                    res_chunks_done,
  output logic                           busy
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LOW, WAIT_IDLE, REPORT} state_t;

  state_t                           state_q, state_d;
  logic [INPUT_ELEMENTS-1:0][31:0]  blobby_q, blobby_d;
  logic [31:0]                      cur_nonce_q, cur_nonce_d;
  logic [15:0]                      chunks_q, chunks_d;
  logic [15:0]                      chunks_done_q, chunks_done_d;
  logic                             abort_pending_q, abort_pending_d;
  logic                             res_found_q, res_found_d;
  logic                             res_aborted_q, res_aborted_d;
  logic [31:0]                      res_nonce_q, res_nonce_d;
  logic [15:0]                      done_inc;

  always_comb begin
    state_d         = state_q;
    blobby_d        = blobby_q;
    cur_nonce_d     = cur_nonce_q;
    chunks_d        = chunks_q;
    chunks_done_d   = chunks_done_q;
    abort_pending_d = abort_pending_q;
    res_found_d     = res_found_q;
    res_aborted_d   = res_aborted_q;
    res_nonce_d     = res_nonce_q;
    scan_start      = 1'b0;
    done_inc        = chunks_done_q + 16'd1;

    // An abort arriving this cycle already counts for this cycle's decision.
    if (abort && (state_q inside {LAUNCH, WAIT_LOW, WAIT_IDLE}))
      abort_pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (job_valid) begin
          blobby_d        = job_blobby;
          cur_nonce_d     = job_first_nonce;
          chunks_d        = job_chunks;
          chunks_done_d   = 16'd0;
          abort_pending_d = 1'b0;
          res_found_d     = 1'b0;
          res_aborted_d   = 1'b0;
          res_nonce_d     = 32'd0;
          state_d         = (job_chunks == 16'd0) ? REPORT : LAUNCH;
        end
      end
      LAUNCH: begin
        // Start is decoded from live scan_idle so it can never fire while busy.
        if (abort_pending_d) begin
          res_aborted_d = 1'b1;
          state_d       = REPORT;
        end else if (scan_idle) begin
          scan_start = 1'b1;
          state_d    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!scan_idle) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (scan_idle) begin
          chunks_done_d = done_inc;
          if (scan_found) begin
            res_found_d = 1'b1;
            res_nonce_d = scan_nonce;
            state_d     = REPORT;
          end else if (done_inc == chunks_q) begin
            state_d = REPORT;
          end else if (abort_pending_d) begin
            res_aborted_d = 1'b1;
            state_d       = REPORT;
          end else begin
            cur_nonce_d = cur_nonce_q + scan_count;
            state_d     = LAUNCH;
          end
        end
      end
      REPORT: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      blobby_q        <= '0;
      cur_nonce_q     <= '0;
      chunks_q        <= '0;
      chunks_done_q   <= '0;
      abort_pending_q <= 1'b0;
      res_found_q     <= 1'b0;
      res_aborted_q   <= 1'b0;
      res_nonce_q     <= '0;
    end else begin
      state_q         <= state_d;
      blobby_q        <= blobby_d;
      cur_nonce_q     <= cur_nonce_d;
      chunks_q        <= chunks_d;
      chunks_done_q   <= chunks_done_d;
      abort_pending_q <= abort_pending_d;
      res_found_q     <= res_found_d;
      res_aborted_q   <= res_aborted_d;
      res_nonce_q     <= res_nonce_d;
    end
  end

  always_comb begin
    scan_blobby             = blobby_q;
    scan_blobby[NONCE_WORD] = cur_nonce_q;
  end

  assign job_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign res_valid       = (state_q == REPORT);
  assign res_found       = res_found_q;
  assign res_aborted     = res_aborted_q;
  assign res_nonce       = res_nonce_q;
  assign res_chunks_done = chunks_done_q;

endmodule

// File: tb/tb_sha3_scan_dispatcher.sv
// Randomized bench for sha3_scan_dispatcher: plays the scanner and compares
// each job's starts and result against an outcome model of the job.
module tb_sha3_scan_dispatcher;
  localparam int NE = 20;
  localparam int NW = 19;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   job_valid = 1'b0;
  logic                   job_ready;
  logic [NE-1:0][31:0]    job_blobby = '0;
  logic [31:0]            job_first_nonce = '0;
  logic [15:0]            job_chunks = '0;
  logic                   abort = 1'b0;
  logic                   scan_start;
  logic [NE-1:0][31:0]    scan_blobby;
  logic                   scan_idle = 1'b1;
  logic                   scan_found = 1'b0;
  logic [31:0]            scan_nonce = '0;
  logic [31:0]            scan_count = '0;
  logic                   res_valid;
  logic                   res_ready = 1'b0;
  logic                   res_found;
  logic                   res_aborted;
  logic [31:0]            res_nonce;
  logic [15:0]            res_chunks_done;
  logic                   busy;

  int checks = 0;
  int failures = 0;

  sha3_scan_dispatcher #(.PROPER(1), .NONCE_WORD(NW)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_blobby(job_blobby), .job_first_nonce(job_first_nonce),
    .job_chunks(job_chunks), .abort(abort), .scan_start(scan_start),
    .scan_blobby(scan_blobby), .scan_idle(scan_idle), .scan_found(scan_found),
    .scan_nonce(scan_nonce), .scan_count(scan_count), .res_valid(res_valid),
    .res_ready(res_ready), .res_found(res_found), .res_aborted(res_aborted),
    .res_nonce(res_nonce), .res_chunks_done(res_chunks_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [767:0] got,
                           input logic [767:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // abort_at: chunk during which abort is pulsed (0 = while LAUNCH is held
  // off by a busy scanner, only used with idle_hold; >chunks = never).
  task automatic run_job(input logic [31:0] first, input logic [15:0] chunks,
                         input logic [31:0] count, input int found_at,
                         input logic [31:0] found_nonce, input int abort_at,
                         input bit idle_hold, input int ready_delay);
    logic [NE-1:0][31:0] blob, exp_b;
    logic [31:0] start_nonce;
    int starts = 0, cyc = 0, exp_done = 0;
    bit exp_found = 0, exp_ab = 0;

    for (int i = 0; i < NE; i++) blob[i] = $urandom;
    @(negedge clk);
    abort = 1'b1;                      // abort while idle must be ignored
    @(negedge clk);
    abort = 1'b0;
    check_val("job_ready_idle", job_ready, 1);
    if (idle_hold) scan_idle = 1'b0;
    job_valid = 1'b1; job_blobby = blob; job_first_nonce = first;
    job_chunks = chunks; scan_count = count;
    @(negedge clk);
    job_valid = 1'b0;
    check_val("busy_after_accept", busy, 1);
    check_val("job_ready_busy", job_ready, 0);
    if (idle_hold) begin
      for (int i = 0; i < 2; i++) begin
        abort = (abort_at == 0 && i == 0);
        #1 check_val("no_start_while_busy", scan_start, 0);
        @(negedge clk);
      end
      abort = 1'b0;
      scan_idle = 1'b1;
    end

    while (!res_valid && cyc < 300) begin
      #1;
      if (scan_start) begin
        starts++;
        start_nonce = first + 32'(starts - 1) * count;
        exp_b = blob;
        exp_b[NW] = start_nonce;
        check_val("start_blobby", scan_blobby, exp_b);
        @(negedge clk);
        scan_idle = 1'b0;
        abort = (abort_at == starts);
        @(negedge clk);
        abort = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check_val("blobby_stable", scan_blobby[NW], start_nonce);
        scan_idle = 1'b1;
        scan_found = (found_at == starts);
        scan_nonce = (found_at == starts) ? found_nonce : $urandom;
        @(negedge clk);
        scan_found = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    check_val("res_valid_timeout", res_valid, 1);

    if (chunks != 0) begin
      if (idle_hold && abort_at == 0) exp_ab = 1;
      else begin
        for (int c = 1; c <= int'(chunks); c++) begin
          exp_done = c;
          if (found_at == c) begin exp_found = 1; break; end
          if (c == int'(chunks)) break;
          if (abort_at == c) begin exp_ab = 1; break; end
        end
      end
    end
    check_val("start_count", starts, exp_done);
    check_val("res_found", res_found, exp_found);
    check_val("res_aborted", res_aborted, exp_ab);
    check_val("res_chunks_done", res_chunks_done, exp_done);
    if (exp_found) check_val("res_nonce", res_nonce, found_nonce);

    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      check_val("hold_valid", res_valid, 1);
      check_val("hold_job_ready", job_ready, 0);
      check_val("hold_done", res_chunks_done, exp_done);
      check_val("hold_found", res_found, exp_found);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_val("released_valid", res_valid, 0);
    check_val("released_job_ready", job_ready, 1);
  endtask

  initial begin
    int ch, fa, aa;
    bit ih;
    #2;
    check_val("rst_busy", busy, 0);
    check_val("rst_scan_blobby", scan_blobby, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_job_ready", job_ready, 1);
    check_val("rst_res_valid", res_valid, 0);

    run_job(32'h100, 16'd3, 32'h40, 0, 32'h0, 99, 0, 0);
    run_job(32'h100, 16'd3, 32'h40, 2, 32'h15A, 99, 0, 1);
    run_job(32'hFFFF_FFE0, 16'd2, 32'h40, 0, 32'h0, 99, 0, 0);
    run_job(32'h1234, 16'd5, 32'h10, 0, 32'h0, 1, 0, 2);
    run_job(32'h55, 16'd0, 32'h10, 0, 32'h0, 99, 0, 10);
    run_job(32'h77, 16'd4, 32'h20, 0, 32'h0, 0, 1, 0);
    run_job(32'h80, 16'd3, 32'h20, 2, 32'h99, 2, 0, 0);
    run_job(32'h90, 16'd2, 32'h20, 0, 32'h0, 2, 0, 0);

    // reset while the scanner is running a chunk
    @(negedge clk);
    job_valid = 1'b1; job_chunks = 16'd5; job_first_nonce = 32'hABC;
    @(negedge clk);
    job_valid = 1'b0;
    #1 check_val("rst_test_start", scan_start, 1);
    @(negedge clk);
    scan_idle = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_busy", busy, 0);
    check_val("async_rst_valid", res_valid, 0);
    check_val("async_rst_blobby", scan_blobby, 0);
    check_val("async_rst_done", res_chunks_done, 0);
    @(negedge clk);
    rst = 1'b0;
    scan_idle = 1'b1;
    @(negedge clk);
    #1;
    check_val("post_rst_job_ready", job_ready, 1);
    check_val("post_rst_start", scan_start, 0);
    run_job(32'h200, 16'd2, 32'h8, 0, 32'h0, 99, 0, 0);

    for (int j = 0; j < 25; j++) begin
      ch = $urandom_range(0, 6);
      fa = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 7);
      ih = $urandom_range(0, 3) == 0;
      aa = ($urandom_range(0, 2) == 0) ? 99 : $urandom_range(1, 6);
      if (ih && $urandom_range(0, 2) == 0) aa = 0;
      run_job($urandom, 16'(ch), $urandom, fa, $urandom, aa, ih,
              $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha3_scan_dispatcher.md
SHA3_SCAN_DISPATCHER -- requirements
Module: sha3_scan_dispatcher

Interface
REQ-001 SHALL have parameter PROPER, default 1: selects header size; INPUT_ELEMENTS = 20 if PROPER, else 24.
REQ-002 SHALL have parameter NONCE_WORD, default 19: index of the blobby word overwritten with the chunk base nonce.
REQ-003 SHALL have clk  in  1: single clock; all logic on posedge clk.
REQ-004 SHALL have rst  in  1: reset, asynchronous and active-high.
REQ-005 SHALL have job_valid  in  1 and job_ready  out  1: job handshake; transfer when both are high.
REQ-006 SHALL have job_blobby  in  32 x INPUT_ELEMENTS: header words.
REQ-007 SHALL have job_first_nonce  in  32 and job_chunks  in  16: base nonce and number of chunks to scan.
REQ-008 SHALL have abort  in  1: single-cycle request to stop the current job.
REQ-009 SHALL have scan_start  out  1 and scan_blobby  out  32 x INPUT_ELEMENTS: scanner start strobe and header.
REQ-010 SHALL have scan_idle, scan_found  in  1 each, scan_nonce  in  32 and scan_count  in  32: scanner status, result and chunk size.
REQ-011 SHALL have res_valid  out  1 and res_ready  in  1: result handshake.
REQ-012 SHALL have res_found, res_aborted  out  1 each, res_nonce  out  32 and res_chunks_done  out  16: result payload.
REQ-013 SHALL have busy  out  1: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT_LOW, WAIT_IDLE and REPORT.
REQ-015 IDLE SHALL drive job_ready=1; on transfer it SHALL latch blobby, first_nonce and chunks, and clear chunks_done and abort_pending.
REQ-016 IDLE with an accepted job_chunks==0 SHALL go to REPORT with found=0 and aborted=0; otherwise it SHALL go to LAUNCH.
REQ-017 LAUNCH SHALL assert scan_start for exactly one cycle, in the first cycle scan_idle==1, then go to WAIT_LOW.
REQ-018 scan_blobby SHALL equal the latched blobby with word NONCE_WORD replaced by cur_nonce, and SHALL stay stable from LAUNCH through WAIT_IDLE.
REQ-019 WAIT_LOW SHALL wait for scan_idle==0, then go to WAIT_IDLE.
REQ-020 WAIT_IDLE SHALL wait for scan_idle==1; in that cycle it SHALL increment chunks_done and sample scan_found and scan_nonce.
REQ-021 On scan_idle==1 in WAIT_IDLE, the next state SHALL be decided with this priority: found -> REPORT(found=1, nonce=scan_nonce); chunks_done==chunks -> REPORT(found=0); abort_pending -> REPORT(aborted=1); else cur_nonce += scan_count and go to LAUNCH.
REQ-022 cur_nonce arithmetic SHALL be 32-bit modulo 2^32 (wraps, no flag); chunks_done SHALL be 16-bit and never exceed chunks.
REQ-023 abort SHALL set abort_pending in LAUNCH, WAIT_LOW and WAIT_IDLE, and SHALL be ignored in IDLE and REPORT.
REQ-024 abort_pending in LAUNCH before scan_start SHALL go to REPORT(aborted=1) without starting the scanner; a running chunk SHALL always complete.
REQ-025 abort coincident with the scan_idle rise SHALL count as pending for that decision; found still takes priority.
REQ-026 REPORT SHALL hold res_valid=1 with stable payload until res_ready==1, then go to IDLE; job_ready SHALL be 0 outside IDLE.
REQ-027 res_chunks_done SHALL reflect chunks completed, including the chunk that found.
REQ-028 scan_start SHALL never be asserted while scan_idle==0.

Reset
REQ-029 rst high SHALL immediately force state to IDLE and clear scan_start, res_valid, res_found, res_aborted, res_nonce, res_chunks_done, busy, abort_pending and cur_nonce; job_ready SHALL be 1 while in IDLE after reset.
REQ-030 rst mid-job SHALL discard the job with no res_valid; scan_blobby after reset SHALL be all zeros.

Verification
REQ-031 Job first_nonce=0x100, chunks=3, scan_count=0x40, scanner never finds -> starts with nonce words 0x100, 0x140, 0x180; result found=0, aborted=0, chunks_done=3.
REQ-032 Same job, scanner finds nonce 0x15A in chunk 2 -> result found=1, nonce=0x15A, chunks_done=2, no third start.
REQ-033 first_nonce=0xFFFFFFE0, scan_count=0x40, chunks=2 -> second start nonce word 0x00000020.
REQ-034 abort during chunk 1 of 5 -> chunk 1 completes; result aborted=1, chunks_done=1; abort in IDLE has no effect.
REQ-035 chunks=0 -> no scan_start; result found=0, chunks_done=0; res_ready held low 10 cycles -> payload stable, job_ready=0.
REQ-036 rst asserted in WAIT_IDLE -> outputs cleared asynchronously, job_ready=1 after release, next job runs normally.
